dmem: RTL and testbench
=======================

# dmem

Single-port 128-bit data memory answering the CPU's data-memory interface: memory enable, write enable, 21-bit address (low 8 bits used), 128-bit write data and 128-bit read data. It sits beside the CPU at the top level and responds to every `MemEn` request with a registered, fixed-latency read or a same-cycle-committed write. After reset it optionally sweeps all 256 words to zero and holds `MemReady` low until the sweep finishes.

## Interface

Parameters:
- `DEPTH`, 256: number of 128-bit words.
- `AW_USED`, 8: address bits decoded, `log2(DEPTH)`.

Ports (bit vectors are big-endian, `[0:N-1]`, bit 0 is MSB):
- `Clk` input 1: the only clock; all state changes on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `MemEn` input 1: access request this cycle; suppresses spurious reads.
- `MemWrEn` input 1: with `MemEn`, 1 selects write and 0 selects read.
- `MemAddr` input `[0:20]`: word address; `[13:20]` is decoded.
- `MemDataIn` input `[0:127]`: write data, driven by the CPU's `DataOut`.
- `MemDataOut` output `[0:127]`: read data, driving the CPU's `DataIn`.
- `MemReady` output 1: high when accesses are accepted.
- `MemAddrErr` output 1: one-cycle pulse flagging an out-of-range address.

## Operation

States:
- `INIT`: active only when the clear sweep is compiled in.
- `READY`.

Reset behaviour:
- When `Reset` is sampled high, on that edge: `MemDataOut`=0, `MemReady`=0, `MemAddrErr`=0, sweep counter=0, state=`INIT`.
- Without the macro: state=`READY`, and `MemReady` is 1 from the first edge after `Reset` deasserts.

`INIT` state:
- Each cycle writes 0 to word `counter`, then increments the counter.
- When the counter reaches 255 (the 256th clear), the state moves to `READY` on that same edge.
- `MemReady` is 0 throughout.
- `MemEn` is ignored; no writes are taken, `MemDataOut` stays 0, and `MemAddrErr` stays 0.

`READY` state:
- Read (`MemEn`=1, `MemWrEn`=0): `MemDataOut <= mem[MemAddr[13:20]]`.
- Write (`MemEn`=1, `MemWrEn`=1): `mem[MemAddr[13:20]] <= MemDataIn`; `MemDataOut` holds its previous value.
- `MemEn`=0: no array access; `MemDataOut` holds.
- `MemAddrErr`: set to 1 for one cycle, on the edge after any access with `MemAddr[0:12] != 0`. The access still proceeds on the low 8 bits (the address wraps modulo 256).

Reset mid-operation:
- Takes priority over any access in that cycle.
- Restarts the sweep from word 0; a partially completed sweep is discarded.

Single port, so there is no simultaneous read and write. Read-after-write to the same address on consecutive cycles returns the newly written data.

## Timing

- Read latency is 1 cycle: a request sampled at edge N gives valid `MemDataOut` after edge N, held until the next read.
- Writes are visible to a read issued on the next cycle.
- Sweep: `MemReady` rises exactly 256 edges after the first edge at which `Reset` is sampled low.
- `MemAddrErr` is asserted for the cycle after edge N, for a request sampled at edge N.
- No combinational path from inputs to outputs.

## Configuration

- Macro `DMEM_INIT_CLEAR_EN`.
- Defined: the `INIT` sweep exists as described, and every word reads 0 until written.
- Undefined:
  - The `INIT` state and the sweep counter are removed.
  - `MemReady` is 1 from the first cycle after `Reset` deasserts.
  - Array contents are undefined until written; reads of unwritten words return X in simulation.

## Structure

- Shared package `dmem_pkg` holds:
  - `DATA_W`=128, `ADDR_W`=21, `DEPTH`=256, `AW_USED`=8.
  - The state encoding, `INIT`=1'b0 and `READY`=1'b1.
- One sub-module, `dmem_array`: a 256×128 synchronous single-port RAM with ports `Clk`, `we`, `addr[0:7]`, `wdata`, `rdata`.
  - Contains no reset, so it can be swapped for a vendor macro.
  - The top level owns the FSM, the sweep counter, write-data/address muxing during `INIT`, the address-error check and the `MemDataOut` register.

## Test plan

- **Reset and sweep:** assert `Reset` for 2 cycles, then release. With the macro, `MemReady`=0 for 256 cycles, then 1. A read of address 0x0A5 returns 0. With `MemEn` pulsed during `INIT`, no write occurs.
- **Write then read:** write `128'hDEADBEEF_…_0123` at 0x07, then read 0x07 on the next cycle. `MemDataOut` equals that value one edge later; a write-only cycle leaves `MemDataOut` unchanged.
- **Address wrap and error:** write 0xAA…AA at `MemAddr`=0x000105. `MemAddrErr` pulses for exactly 1 cycle, and a read of 0x05 returns 0xAA…AA.
- **Idle hold:** after a read, hold `MemEn`=0 for 10 cycles. `MemDataOut` is stable, and `MemAddrErr`=0.
- **Reset mid-sweep:** reassert `Reset` at sweep count 100. The sweep restarts from 0, and `MemReady` rises 256 cycles after the second release.
- **Back-to-back reads:** read addresses 0..255 on consecutive cycles after filling each word with its own index. Each `MemDataOut` equals the address from one cycle earlier.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the 128-bit data memory.
package dmem_pkg;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ADDR_W  = 21;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned AW_USED = 8;

    // INIT only exists when the power-up clear sweep is compiled in.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// 256x128 single-port storage: synchronous write, combinational read.
// No reset so it can be replaced by a vendor RAM macro; the top level
// owns the output register that gives the one-cycle read latency.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 128
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [0:AW-1] addr,
    input  logic [0:DW-1] wdata,
    output logic [0:DW-1] rdata
);

    logic [0:DW-1] mem [WORDS];

    // Write port: commits on the rising edge.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem.sv
// Data memory for the CPU data-memory interface.
// Optional power-up clear sweep is enabled by defining DMEM_INIT_CLEAR_EN;
// without it the memory is ready one edge after reset and contents are
// undefined until written.
module dmem
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned AW_USED = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemEn,
    input  logic              MemWrEn,
    input  logic [0:ADDR_W-1] MemAddr,
    input  logic [0:DATA_W-1] MemDataIn,
    output logic [0:DATA_W-1] MemDataOut,
    output logic              MemReady,
    output logic              MemAddrErr
);

    logic [0:AW_USED-1] req_addr;
    logic               addr_hi_nz;
    logic               arr_we;
    logic [0:AW_USED-1] arr_addr;
    logic [0:DATA_W-1]  arr_wdata;
    logic [0:DATA_W-1]  arr_rdata;

    // Low AW_USED bits select the word; any upper bit set is flagged but wraps.
    assign req_addr   = MemAddr[ADDR_W-AW_USED:ADDR_W-1];
    assign addr_hi_nz = |MemAddr[0:ADDR_W-AW_USED-1];

`ifdef DMEM_INIT_CLEAR_EN
    dmem_state_e        state;
    logic [0:AW_USED-1] sweep_cnt;
`endif

    // Array port mux: sweep owns the port during INIT, reset blocks all writes.
    always_comb begin
        arr_we    = 1'b0;
        arr_addr  = req_addr;
        arr_wdata = MemDataIn;
        if (Reset) begin
            arr_we = 1'b0;
        end
`ifdef DMEM_INIT_CLEAR_EN
        else if (state == INIT) begin
            arr_we    = 1'b1;
            arr_addr  = sweep_cnt;
            arr_wdata = '0;
        end
`endif
        else begin
            arr_we = MemEn && MemWrEn;
        end
    end

    // Control FSM with registered read data, ready and address-error outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            MemDataOut <= '0;
            MemReady   <= 1'b0;
            MemAddrErr <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
            state      <= INIT;
            sweep_cnt  <= '0;
`endif
        end else begin
            MemAddrErr <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
            if (state == INIT) begin
                sweep_cnt <= sweep_cnt + 1'b1;
                if (sweep_cnt == AW_USED'(DEPTH - 1)) begin
                    state    <= READY;
                    MemReady <= 1'b1;
                end
            end else begin
`endif
                MemReady <= 1'b1;
                if (MemEn) begin
                    if (!MemWrEn) begin
                        MemDataOut <= arr_rdata;
                    end
                    MemAddrErr <= addr_hi_nz;
                end
`ifdef DMEM_INIT_CLEAR_EN
            end
`endif
        end
    end

    dmem_array #(
        .WORDS (DEPTH),
        .AW    (AW_USED),
        .DW    (DATA_W)
    ) u_array (
        .Clk   (Clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem; sweep-specific checks are active
// when DMEM_INIT_CLEAR_EN is defined.
module tb_dmem;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         MemEn = 1'b0;
    logic         MemWrEn = 1'b0;
    logic [0:20]  MemAddr = '0;
    logic [0:127] MemDataIn = '0;
    logic [0:127] MemDataOut;
    logic         MemReady;
    logic         MemAddrErr;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] PatA  = 128'hDEADBEEF_0011_2233_4455_6677_8899_0123;
    localparam logic [127:0] PatB  = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] PatAA = {16{8'hAA}};
    localparam logic [127:0] Ones  = '1;

    always #5 Clk = ~Clk;

    dmem u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MemEn      (MemEn),
        .MemWrEn    (MemWrEn),
        .MemAddr    (MemAddr),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .MemReady   (MemReady),
        .MemAddrErr (MemAddrErr)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [0:20] a, input logic [127:0] d);
        MemEn     = 1'b1;
        MemWrEn   = we;
        MemAddr   = a;
        MemDataIn = d;
        step();
        MemEn     = 1'b0;
        MemWrEn   = 1'b0;
    endtask

    // Counts edges from release until MemReady rises; optionally pokes a write
    // while still initialising to prove it is ignored.
    task automatic wait_ready(output int edges, input bit poke);
        edges = 0;
        while (!MemReady && edges < 1000) begin
            if (poke && edges == 10) begin
                MemEn     = 1'b1;
                MemWrEn   = 1'b1;
                MemAddr   = 21'h000102;
                MemDataIn = Ones;
            end else begin
                MemEn   = 1'b0;
                MemWrEn = 1'b0;
            end
            step();
            edges++;
            if (poke && edges == 11) check_eq("init_no_addr_err", 128'(MemAddrErr), 128'd0);
        end
        MemEn   = 1'b0;
        MemWrEn = 1'b0;
    endtask

    initial begin
        int edges;

        // Reset held for two edges.
        Reset = 1'b1;
        step();
        step();
        check_eq("reset_dout", MemDataOut, 128'd0);
        check_eq("reset_ready", 128'(MemReady), 128'd0);
        check_eq("reset_err", 128'(MemAddrErr), 128'd0);
        Reset = 1'b0;

`ifdef DMEM_INIT_CLEAR_EN
        wait_ready(edges, 1'b1);
        check_eq("sweep_edges", 128'(edges), 128'd256);
        check_eq("sweep_dout_zero", MemDataOut, 128'd0);
        access(1'b0, 21'h0000A5, '0);
        check_eq("read_cleared_a5", MemDataOut, 128'd0);
        access(1'b0, 21'h000002, '0);
        check_eq("init_write_ignored", MemDataOut, 128'd0);
`else
        step();
        check_eq("ready_after_release", 128'(MemReady), 128'd1);
`endif

        // Write then read, then a write-only cycle must not disturb the output.
        access(1'b1, 21'h000007, PatA);
        access(1'b0, 21'h000007, '0);
        check_eq("raw_07", MemDataOut, PatA);
        check_eq("raw_07_err", 128'(MemAddrErr), 128'd0);
        access(1'b1, 21'h000020, PatB);
        check_eq("write_holds_dout", MemDataOut, PatA);
        access(1'b0, 21'h000020, '0);
        check_eq("read_20", MemDataOut, PatB);

        // Out-of-range address wraps and pulses the error for one cycle.
        access(1'b1, 21'h000105, PatAA);
        check_eq("wrap_err_pulse", 128'(MemAddrErr), 128'd1);
        step();
        check_eq("wrap_err_clear", 128'(MemAddrErr), 128'd0);
        access(1'b0, 21'h000005, '0);
        check_eq("wrap_read_05", MemDataOut, PatAA);
        check_eq("inrange_no_err", 128'(MemAddrErr), 128'd0);

        // Idle cycles hold the output.
        MemAddr = 21'h000007;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("idle_dout_%0d", i), MemDataOut, PatAA);
            check_eq($sformatf("idle_err_%0d", i), 128'(MemAddrErr), 128'd0);
        end

        // Fill every word with its index, then stream reads back to back.
        for (int i = 0; i < 256; i++) begin
            access(1'b1, 21'(i), 128'(i));
        end
        MemEn   = 1'b1;
        MemWrEn = 1'b0;
        for (int i = 0; i < 256; i++) begin
            MemAddr = 21'(i);
            step();
            check_eq($sformatf("b2b_%0d", i), MemDataOut, 128'(i));
        end
        MemEn = 1'b0;

`ifdef DMEM_INIT_CLEAR_EN
        // Reset in the middle of a sweep restarts it from word 0.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check_eq("midsweep_not_ready", 128'(MemReady), 128'd0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        wait_ready(edges, 1'b0);
        check_eq("midsweep_edges", 128'(edges), 128'd256);
        access(1'b0, 21'h0000A5, '0);
        check_eq("midsweep_cleared_a5", MemDataOut, 128'd0);
`else
        // Reset wins over a write presented in the same cycle.
        Reset     = 1'b1;
        MemEn     = 1'b1;
        MemWrEn   = 1'b1;
        MemAddr   = 21'h000009;
        MemDataIn = Ones;
        step();
        MemEn   = 1'b0;
        MemWrEn = 1'b0;
        check_eq("midreset_ready_low", 128'(MemReady), 128'd0);
        check_eq("midreset_dout_zero", MemDataOut, 128'd0);
        Reset = 1'b0;
        step();
        check_eq("midreset_ready_high", 128'(MemReady), 128'd1);
        access(1'b0, 21'h000009, '0);
        check_eq("reset_blocks_write", MemDataOut, 128'd9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
